// File: rtl/cmp_pkg.sv
// Shared types and sizing for the bit-serial comparator path.
// Frame length depends on CMP_SER_PARITY_EN (adds one even-parity bit per frame).
// No logic of its own; no handshake.
package cmp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    localparam int CMP_WIDTH = 8;

    function automatic int cmp_flen(input int width);
`ifdef CMP_SER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/cmp_ser_tx_if.sv
// Parallel operand handshake plus serial frame outputs of the operand transmitter.
// No storage; latency is set by the transmitter.
// in_valid/in_ready handshake on the parallel side; the serial side has no backpressure.
interface cmp_ser_tx_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_bit;
    logic             ser_vld;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_bit, ser_vld, ser_first, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_bit, ser_vld, ser_first, ser_last, busy
    );
endinterface

// File: rtl/cmp_bitcnt.sv
// Loadable down-counter tracking position within a serial frame, with registered full/one flags.
// Latency: flags describe the count held after the same edge that loads or decrements it.
// No backpressure; load takes priority over dec and the count never goes below zero.
module cmp_bitcnt #(
    parameter int CW   = 4,
    parameter int FLEN = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          is_full,
    output logic          is_one
);
    localparam logic [CW-1:0] FULL_C = CW'(FLEN);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE_C;
        end
    end

    // Flags are computed from the next count so they come straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            is_full <= 1'b0;
            is_one  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            is_full <= (cnt_d == FULL_C);
            is_one  <= (cnt_d == ONE_C);
        end
    end
endmodule

// File: rtl/cmp_ser_tx.sv
// Bit-serial operand transmitter: parallel word in, MSB-first frame out with first/last markers.
// Latency: first bit the cycle after accept, FLEN bits per frame, back-to-back with no gap.
// Backpressure: in_ready only when idle or on a frame's last bit; CMP_SER_PARITY_EN appends even parity.
module cmp_ser_tx
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    cmp_ser_tx_if.slave bus
);
    localparam int FLEN = cmp_flen(WIDTH);
    localparam int CW   = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FLEN_C = CW'(FLEN);

    tx_state_e       state_q;
    tx_state_e       state_d;
    logic [FLEN-1:0] sr_q;
    logic [FLEN-1:0] frame;
    logic            accept;
    logic            cnt_full;
    logic            cnt_one;
    logic            shifting;

    assign shifting     = (state_q == SHIFT);
    assign bus.in_ready = (state_q == IDLE) || cnt_one;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef CMP_SER_PARITY_EN
    assign frame = {bus.in_data, ^bus.in_data};
`else
    assign frame = bus.in_data;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (cnt_one && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Zero fill means the register is empty again once a frame drains, so ser_bit idles at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sr_q <= frame;
            end else if (shifting) begin
                sr_q <= {sr_q[FLEN-2:0], 1'b0};
            end
        end
    end

    cmp_bitcnt #(
        .CW   (CW),
        .FLEN (FLEN)
    ) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (FLEN_C),
        .dec      (shifting && !accept),
        .is_full  (cnt_full),
        .is_one   (cnt_one)
    );

    assign bus.ser_bit   = sr_q[FLEN-1];
    assign bus.ser_vld   = shifting;
    assign bus.busy      = shifting;
    assign bus.ser_first = cnt_full;
    assign bus.ser_last  = cnt_one;
endmodule

// File: tb/tb_cmp_ser_tx.sv
// Bench for cmp_ser_tx: directed frames then random traffic against a bit-queue reference model.
module tb_cmp_ser_tx;
    import cmp_pkg::*;

    localparam int W = CMP_WIDTH;
`ifdef CMP_SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        bit b;
        bit first;
        bit last;
    } sbit_t;

    logic clk = 1'b0;
    logic rst;

    cmp_ser_tx_if #(.WIDTH(W)) bus ();

    cmp_ser_tx #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Bits still to appear on the serial output; element 0 is the current cycle.
    sbit_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        bit eb;
        bit ef;
        bit el;
        ev = (exp_q.size() != 0);
        eb = ev ? exp_q[0].b : 1'b0;
        ef = ev ? exp_q[0].first : 1'b0;
        el = ev ? exp_q[0].last : 1'b0;
        chk("in_ready",  bus.in_ready,  exp_q.size() <= 1);
        chk("ser_vld",   bus.ser_vld,   ev);
        chk("busy",      bus.busy,      ev);
        chk("ser_bit",   bus.ser_bit,   eb);
        chk("ser_first", bus.ser_first, ef);
        chk("ser_last",  bus.ser_last,  el);
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r);
        bit    acc;
        sbit_t s;
        if (r) begin
            exp_q.delete();
        end else begin
            acc = v && (exp_q.size() <= 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) begin
                    s.b     = d[i];
                    s.first = (i == W - 1);
                    s.last  = (i == 0) && !PAR;
                    exp_q.push_back(s);
                end
                if (PAR) begin
                    s.b     = ^d;
                    s.first = 1'b0;
                    s.last  = 1'b1;
                    exp_q.push_back(s);
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        @(negedge clk);
        check_outputs();
        bus.in_valid = v;
        bus.in_data  = d;
        rst          = r;
        @(posedge clk);
        model_edge(v, d, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b0);
    endtask

    task automatic send(input logic [W-1:0] d);
        bit done;
        done = 1'b0;
        while (!done) begin
            done = (exp_q.size() <= 1);
            cycle(1'b1, d, 1'b0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        idle(20);

        send(W'('hA5));
        idle(12);

        send(W'('hA5));
        send(W'('h3C));
        idle(20);

        send(W'('hA5));
        idle(2);
        send(W'('hFF));
        idle(15);

        send(W'('hA5));
        idle(3);
        cycle(1'b0, W'($urandom), 1'b1);
        idle(3);
        send(W'('h01));
        idle(12);

        send(W'('h07));
        send(W'('hA5));
        idle(12);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: send(W'($urandom));
                6, 7, 8:          idle($urandom_range(1, 4));
                default:          cycle(1'b0, W'($urandom), $urandom_range(0, 3) == 0);
            endcase
        end
        idle(W + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cmp_ser_tx.md
# cmp_ser_tx

Bit-serial operand transmitter feeding the bit-serial comparator's `cmp_in_a` input. Accepts a parallel word over a valid/ready handshake and emits it one bit per clock, MSB first, with frame markers so the comparator can align its per-frame state. It sits between the operand register file and the comparator. It supports back-to-back frames with no idle cycle.

## Interface

- `WIDTH`, 8: operand width in bits; legal range 2..32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: parallel operand valid.
- `in_ready` out 1: transmitter can accept an operand this cycle.
- `in_data` in WIDTH: parallel operand.
- `ser_bit` out 1: serial data bit; drives comparator `cmp_in_a`.
- `ser_vld` out 1: `ser_bit` is meaningful this cycle.
- `ser_first` out 1: current bit is the first bit of a frame (MSB).
- `ser_last` out 1: current bit is the last bit of a frame.
- `busy` out 1: a frame is in flight.

## Operation

- States:
  - IDLE: no frame in flight.
  - SHIFT: a frame is being emitted.
- Accept: an operand is accepted when `in_valid && in_ready` at a clock edge. `in_data` is captured into the shift register and the bit counter is loaded with the frame length FLEN.
  - FLEN = WIDTH by default (see Configuration).
- IDLE:
  - `in_ready`=1; serial outputs are 0.
  - On accept, go to SHIFT.
- SHIFT:
  - Each cycle presents the shift-register MSB on `ser_bit` with `ser_vld`=1.
  - Shift left one bit, filling with 0; decrement the counter.
  - `ser_first`=1 when counter == FLEN.
  - `ser_last`=1 when counter == 1.
- `in_ready` = IDLE, or (SHIFT and counter == 1). This gives a single-entry overlap with no skid buffer.
- On the last bit:
  - If accept: reload and stay in SHIFT. The next frame's first bit follows immediately.
  - Otherwise: go to IDLE.
- `in_data` is sampled only on accept. Changes at any other time have no effect.
- `in_valid` while `in_ready`=0 is held off. The source must hold `in_valid` and `in_data` stable until accepted.
- All outputs are registered except `in_ready`, which is decoded from registered state only and has no combinational path from `in_valid`.
- Counter width: $clog2(WIDTH+2) bits. The counter never wraps below 0; it is reloaded or the FSM goes to IDLE at 1.

## Timing

- Reset values: state=IDLE, `ser_bit`=0, `ser_vld`=0, `ser_first`=0, `ser_last`=0, `busy`=0, counter=0, shift register=0, so `in_ready`=1 in the cycle after reset.
- Latency: accept at edge t, first bit valid in cycle t+1, last bit in cycle t+FLEN.
- Throughput: one operand per FLEN cycles when `in_valid` is held continuously. `ser_vld` stays high with no gaps.
- `busy` = `ser_vld`.
- Reset mid-frame: abort the frame. All outputs take their reset values the cycle after `rst` is sampled high. No partial frame resumes.
- `rst` and `in_valid` high together: reset wins and no accept occurs.

## Configuration

- `CMP_SER_PARITY_EN` defined:
  - FLEN = WIDTH+1. After the LSB, one extra bit is sent carrying even parity: XOR of all WIDTH data bits, computed at accept.
  - `ser_last` marks the parity bit.
  - Parity is registered at accept, so a mid-frame change of `in_data` has no effect.
- `CMP_SER_PARITY_EN` undefined:
  - FLEN = WIDTH. No parity logic or register is present.
  - `ser_last` marks the LSB.

## Structure

- Shared package `cmp_pkg`:
  - State encoding typedef (IDLE=1'b0, SHIFT=1'b1).
  - Default `CMP_WIDTH`=8.
  - Localparam function for FLEN from WIDTH and the parity macro.
- One sub-module `cmp_bitcnt`:
  - Loadable down-counter with a `load` input, load value, `dec` input, and outputs `is_full` (== FLEN) and `is_one` (== 1).
  - The top holds the FSM, shift register and parity.

## Test plan

Frame bits below are shown as `ser_bit` values, one per cycle, for WIDTH=8.

- Reset then idle:
  - Stimulus: `rst` high 2 cycles, then low.
  - Required: all outputs 0 except `in_ready`=1; no `ser_vld` for 20 idle cycles.
- Single frame:
  - Stimulus: accept 0xA5 at edge t.
  - Required: cycles t+1..t+8 carry 1,0,1,0,0,1,0,1; `ser_first` only at t+1, `ser_last` only at t+8; IDLE at t+9.
- Back-to-back:
  - Stimulus: `in_valid` held with 0xA5 then 0x3C.
  - Required: second frame 0,0,1,1,1,1,0,0 starts at t+9; `ser_vld` continuous over t+1..t+16; `in_ready` high only at t and t+8.
- Backpressure:
  - Stimulus: `in_valid` asserted at t+3 mid-frame with 0xFF.
  - Required: not accepted until edge t+8; 0xA5 frame unaltered; 0xFF frame starts at t+9.
- Reset mid-frame:
  - Stimulus: `rst` at cycle t+4 of a 0xA5 frame.
  - Required: all outputs 0 from t+5; next accept of 0x01 yields 0,0,0,0,0,0,0,1.
- Parity (`CMP_SER_PARITY_EN`):
  - 0xA5 → 9 bits, ninth bit 0, `ser_last` on the ninth bit.
  - 0x07 → ninth bit 1.
  - Back-to-back period becomes 9 cycles.
